// File: rtl/forth_boot_loader.sv
// Boot loader for the forth core: takes a byte-stream program image (length, big-endian words,
// XOR checksum), writes it into instruction RAM, then releases the core from reset.
module forth_boot_loader #(
    parameter int iaddr_width = 10,
    parameter int instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [iaddr_width-1:0] imem_addr,
    output logic [instr_width-1:0] imem_wdata,
    output logic                   imem_we,
    output logic                   core_reset,
    input  logic                   boot_req,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             dbg_state
);

    // Byte handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready depends
    // only on state, and rx_data is ignored unless a transfer happens.
    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CSUM    = 3'd4,
        RUN     = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam int unsigned DEPTH = 2 ** iaddr_width;

    state_t               state, state_n;
    logic [15:0]          len_q;
    logic [iaddr_width:0] cnt;
    logic [iaddr_width:0] cnt_inc;
    logic [7:0]           csum;
    logic [7:0]           hi_byte;
    logic [15:0]          len_full;
    logic                 xfer;

    assign rx_ready  = (state != RUN) && (state != ERROR);
    assign xfer      = rx_valid && rx_ready;
    assign len_full  = {len_q[15:8], rx_data};
    assign cnt_inc   = cnt + 1'b1;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        case (state)
            LEN_HI:  if (xfer) state_n = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (32'(len_full) > DEPTH)
                        state_n = ERROR;
                    else if (len_full == 16'd0)
                        state_n = CSUM;
                    else
                        state_n = DATA_HI;
                end
            end
            DATA_HI: if (xfer) state_n = DATA_LO;
            DATA_LO: begin
                // Counter is zero-extended so a full-depth image terminates correctly.
                if (xfer) state_n = (16'(cnt_inc) == len_q) ? CSUM : DATA_HI;
            end
            CSUM:    if (xfer) state_n = (rx_data == csum) ? RUN : ERROR;
            RUN:     if (boot_req) state_n = LEN_HI;
            ERROR:   state_n = ERROR;
            default: state_n = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LEN_HI;
            len_q      <= '0;
            cnt        <= '0;
            csum       <= '0;
            hi_byte    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state   <= state_n;
            imem_we <= 1'b0;
            case (state)
                LEN_HI: if (xfer) len_q[15:8] <= rx_data;
                LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= rx_data;
                        cnt        <= '0;
                        if (32'(len_full) > DEPTH) error <= 1'b1;
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                    end
                end
                DATA_LO: begin
                    // Write lands one cycle later, overlapping the next word's high byte.
                    if (xfer) begin
                        csum       <= csum ^ rx_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= cnt[iaddr_width-1:0];
                        imem_wdata <= {hi_byte, rx_data};
                        cnt        <= cnt_inc;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (rx_data == csum) begin
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (boot_req) begin
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        csum       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_forth_boot_loader.sv
// Directed bench for forth_boot_loader: image streams in, RAM writes checked against an
// expected-write queue filled as data bytes are driven.
module tb_forth_boot_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          imem_we;
    logic          core_reset;
    logic          boot_req = 1'b0;
    logic          done;
    logic          error;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;

    logic [AW+15:0] exp_q[$];
    logic [15:0]    words[$];

    forth_boot_loader #(.iaddr_width(AW), .instr_width(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_we    (imem_we),
        .core_reset (core_reset),
        .boot_req   (boot_req),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe cycle must match the next queued write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [AW+15:0] e;
            writes_seen++;
            if (exp_q.size() == 0) begin
                e = '1;
                check("unexpected_write", {6'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("imem_write", {6'd0, imem_addr, imem_wdata}, {6'd0, e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input bit gaps, input logic [7:0] csum_flip);
        logic [7:0]  cs;
        logic [15:0] len;
        cs  = 8'h00;
        len = 16'(words.size());
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        for (int i = 0; i < words.size(); i++) begin
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8], gaps);
            exp_q.push_back({AW'(i), words[i]});
            send_byte(words[i][7:0], gaps);
        end
        send_byte(cs ^ csum_flip, gaps);
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk); #1;
        boot_req = 1'b0;
    endtask

    task automatic load_stream_a();
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'hABCD);
        words.push_back(16'h8001);
    endtask

    task automatic check_loaded(input string tag, input int n_writes);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_writes"}, 32'(writes_seen), 32'(n_writes));
    endtask

    initial begin
        // reset values
        #12;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr_data", {6'd0, imem_addr, imem_wdata}, 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back good image; done must be up right after the C1 edge
        load_stream_a();
        writes_seen = 0;
        send_image(1'b0, 8'h00);
        check("a_done_next_cycle", 32'(done), 32'd1);
        check_loaded("a", 3);

        pulse_boot();
        check("boot_core_reset", 32'(core_reset), 32'd1);
        check("boot_done", 32'(done), 32'd0);
        check("boot_rx_ready", 32'(rx_ready), 32'd1);

        // single word FFFF
        words.delete();
        words.push_back(16'hFFFF);
        writes_seen = 0;
        send_image(1'b0, 8'h00);
        check_loaded("ffff", 1);

        // empty image
        pulse_boot();
        words.delete();
        writes_seen = 0;
        send_image(1'b0, 8'h00);
        check_loaded("empty", 0);

        // stream A with random rx_valid gaps
        pulse_boot();
        load_stream_a();
        writes_seen = 0;
        send_image(1'b1, 8'h00);
        check_loaded("gaps", 3);

        // full-depth image
        pulse_boot();
        words.delete();
        for (int i = 0; i < 1024; i++) words.push_back(16'($urandom));
        writes_seen = 0;
        send_image(1'b0, 8'h00);
        check_loaded("full", 1024);
        check("full_last_addr", 32'(imem_addr), 32'h3FF);

        // abort with async reset between DATA_HI and DATA_LO
        pulse_boot();
        writes_seen = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("abort_we", 32'(imem_we), 32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr_data", {6'd0, imem_addr, imem_wdata}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", 32'(writes_seen), 32'd0);

        // bad checksum: writes still happen, then ERROR
        load_stream_a();
        writes_seen = 0;
        send_image(1'b0, 8'h01);
        @(negedge clk);
        check("bad_error", 32'(error), 32'd1);
        check("bad_core_reset", 32'(core_reset), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_rx_ready", 32'(rx_ready), 32'd0);
        check("bad_writes", 32'(writes_seen), 32'd3);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        boot_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        boot_req = 1'b0;
        check("err_rx_ready_held", 32'(rx_ready), 32'd0);
        check("err_sticky", 32'(error), 32'd1);
        check("err_core_reset_held", 32'(core_reset), 32'd1);
        check("err_no_extra_write", 32'(writes_seen), 32'd3);

        // oversize length 1025
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("rst2_error_cleared", 32'(error), 32'd0);
        @(posedge clk); #1;
        writes_seen = 0;
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        check("big_error", 32'(error), 32'd1);
        check("big_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("big_no_write", 32'(writes_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forth_boot_loader.md
Name: forth_boot_loader

Overview:
- Upstream companion of the forth core: receives a program image as a byte stream, writes it into the core's instruction RAM, then releases the core from reset.
- Holds the core in reset during loading and on error.
- Image is a 16-bit word count, big-endian words, and a 1-byte XOR checksum.

Parameters:
iaddr_width, 10, instruction RAM address width; RAM depth = 2**iaddr_width words
instr_width, 16, instruction word width; fixed at 16, two bytes per word

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset; asynchronous, active-low
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
imem_addr  output  iaddr_width  instruction RAM write address
imem_wdata  output  instr_width  instruction RAM write data
imem_we  output  1  instruction RAM write strobe, one cycle per word
core_reset  output  1  drives the core's synchronous active-high reset
boot_req  input  1  single-cycle request to reload; honoured only in RUN
done  output  1  image loaded and verified, core running
error  output  1  load failed, core held in reset

Behaviour:
- One clock domain. reset_n asynchronously clears all state. State = LEN_HI, word counter = 0, checksum = 0x00, imem_we = 0, core_reset = 1, done = 0, error = 0, imem_addr = 0, imem_wdata = 0.
- Byte transfer happens on a rising edge with rx_valid & rx_ready.
- rx_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM; 0 in RUN and ERROR.
- States:
  - LEN_HI: transfer stores len[15:8], go to LEN_LO.
  - LEN_LO: transfer stores len[7:0] and clears the word counter.
    - len > 2**iaddr_width: go to ERROR.
    - len = 0: go to CSUM.
    - otherwise: go to DATA_HI.
  - DATA_HI: transfer stores high byte, XORs it into checksum, go to DATA_LO.
  - DATA_LO: transfer XORs the byte into checksum.
    - Next cycle: imem_we = 1 for exactly one cycle, imem_addr = counter, imem_wdata = {high, low}. The write is one cycle after the low-byte transfer, and the counter increments in the same cycle.
    - If counter+1 = len, go to CSUM; else go to DATA_HI.
  - CSUM: transfer compares the byte with the running checksum.
    - Equal: go to RUN.
    - Not equal: go to ERROR.
  - RUN:
    - core_reset = 0, done = 1, both registered: they change the cycle after the CSUM transfer edge.
    - The core starts fetching from address 0 on the following cycle.
    - boot_req = 1 sets core_reset = 1, done = 0, checksum = 0 and goes to LEN_HI.
  - ERROR: error = 1, core_reset = 1, rx_ready = 0. Exit only via reset_n.
- boot_req is ignored outside RUN.
- Word counter is iaddr_width+1 bits so len = 2**iaddr_width is legal and fills the RAM exactly. len compares against the zero-extended counter.
- rx_valid is allowed to drop at any time; the loader waits with no timeout. rx_data is sampled only on a transfer.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- Back-to-back bytes (rx_valid held high) sustain 1 byte/cycle with no bubbles. The strobe of word k overlaps the high-byte transfer of word k+1.
- reset_n asserted mid-load aborts immediately: imem_we = 0, core_reset = 1. RAM contents are undefined, and a full image must be resent.
- Checksum covers data bytes only, not the length or checksum bytes. For len = 0 the expected checksum is 0x00.

Test Plan:
- Stream 00 03 12 34 AB CD 80 01 C1 at 1 byte/cycle:
  - writes (0,0x1234), (1,0xABCD), (2,0x8001), each imem_we one cycle wide.
  - done = 1 and core_reset = 0 one cycle after the C1 transfer; error = 0.
- Same stream with checksum byte C0:
  - all three writes occur, then error = 1, core_reset stays 1, rx_ready = 0.
  - Further bytes are not accepted.
- Stream 04 01 (len = 1025, iaddr_width = 10):
  - error = 1 after the second byte, no imem_we.
- Stream 04 00 plus 2048 data bytes and checksum:
  - last write at address 0x3FF, then done = 1.
- Stream 00 00 00:
  - no writes, done = 1.
- Reload and abort:
  - After a successful load, pulse boot_req: core_reset = 1, done = 0, rx_ready = 1.
  - Load stream 00 01 FF FF 00: write (0,0xFFFF), done = 1.
  - Separately, assert reset_n low between DATA_HI and DATA_LO: outputs return to reset values asynchronously and no write occurs.
- Random rx_valid gaps (about 50% duty) on the first stream:
  - identical writes and final state as the back-to-back run.
